// File: rtl/pcie_tlp_tx_engine.sv
// rtl/pcie_tlp_tx_engine.sv - MWr32/CplD TLP transmit engine onto the PCIe core AXI-stream TX port.
// Optional build macro TX_CFG_DEFER_EN: grant config TLPs only between packets.
module pcie_tlp_tx_engine #(
   parameter int MAX_PAYLOAD_DW = 32,
   parameter int BUF_AV_MIN     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        user_lnk_up,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_type,
   input  logic [9:0]  cmd_len,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_tag,
   input  logic [15:0] cmd_req_id,
   input  logic [15:0] cmd_cpl_id,
   input  logic [11:0] cmd_byte_count,
   input  logic [6:0]  cmd_lower_addr,
   input  logic [31:0] dat_data,
   input  logic        dat_valid,
   output logic        dat_ready,
   input  logic        s_axis_tx_tready,
   output logic [31:0] s_axis_tx_tdata,
   output logic [3:0]  s_axis_tx_tkeep,
   output logic [3:0]  s_axis_tx_tuser,
   output logic        s_axis_tx_tlast,
   output logic        s_axis_tx_tvalid,
   input  logic [5:0]  tx_buf_av,
   input  logic        tx_err_drop,
   input  logic        tx_cfg_req,
   output logic        tx_cfg_gnt,
   output logic        err_len,
   output logic [7:0]  drop_count,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, WAIT_BUF, HDR0, HDR1, HDR2, DATA} state_t;

   localparam logic [9:0] MAX_LEN = 10'(MAX_PAYLOAD_DW);
   localparam logic [5:0] BUF_MIN = 6'(BUF_AV_MIN);

   state_t      state;
   logic        type_q;
   logic [9:0]  len_q;
   logic [9:0]  cnt_q;
   logic [31:0] addr_q;
   logic [7:0]  tag_q;
   logic [15:0] req_id_q;
   logic [15:0] cpl_id_q;
   logic [11:0] bc_q;
   logic [6:0]  la_q;
   logic        len_bad;
   logic        cfg_hold;

   assign len_bad = (cmd_len == 10'd0) || (cmd_len > MAX_LEN);

`ifdef TX_CFG_DEFER_EN
   assign cfg_hold   = tx_cfg_req;
   assign tx_cfg_gnt = (state == IDLE) || (state == WAIT_BUF);
`else
   assign cfg_hold   = tx_cfg_req & 1'b0;
   assign tx_cfg_gnt = 1'b1;
`endif

   assign s_axis_tx_tkeep = 4'hF;
   assign s_axis_tx_tuser = 4'b0000;
   assign busy            = (state != IDLE);
   assign cmd_ready       = (state == IDLE) && user_lnk_up && !rst;

   // Beats are gated by link-up so nothing transfers in the cycle the link is lost.
   always_comb begin
      s_axis_tx_tvalid = 1'b0;
      s_axis_tx_tdata  = 32'h0;
      s_axis_tx_tlast  = 1'b0;
      dat_ready        = 1'b0;
      unique case (state)
         HDR0: begin
            s_axis_tx_tvalid = user_lnk_up;
            s_axis_tx_tdata  = (type_q ? 32'h4A00_0000 : 32'h4000_0000) | {22'd0, len_q};
         end
         HDR1: begin
            s_axis_tx_tvalid = user_lnk_up;
            s_axis_tx_tdata  = type_q ? {cpl_id_q, 4'b0000, bc_q}
                                      : {req_id_q, tag_q, (len_q == 10'd1) ? 4'h0 : 4'hF, 4'hF};
         end
         HDR2: begin
            s_axis_tx_tvalid = user_lnk_up;
            s_axis_tx_tdata  = type_q ? {req_id_q, tag_q, 1'b0, la_q} : (addr_q & 32'hFFFF_FFFC);
         end
         DATA: begin
            s_axis_tx_tvalid = dat_valid & user_lnk_up;
            s_axis_tx_tdata  = dat_data;
            s_axis_tx_tlast  = (cnt_q == 10'd1);
            dat_ready        = s_axis_tx_tready & user_lnk_up;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         err_len    <= 1'b0;
         drop_count <= 8'd0;
         cnt_q      <= 10'd0;
      end else begin
         err_len <= 1'b0;
         if (tx_err_drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;

         if (state == IDLE) begin
            if (cmd_valid && user_lnk_up) begin
               type_q   <= cmd_type;
               len_q    <= cmd_len;
               cnt_q    <= cmd_len;
               addr_q   <= cmd_addr;
               tag_q    <= cmd_tag;
               req_id_q <= cmd_req_id;
               cpl_id_q <= cmd_cpl_id;
               bc_q     <= cmd_byte_count;
               la_q     <= cmd_lower_addr;
               if (len_bad)
                  err_len <= 1'b1;
               else
                  state <= WAIT_BUF;
            end
         end else if (!user_lnk_up) begin
            state   <= IDLE;
            err_len <= 1'b1;
         end else begin
            unique case (state)
               WAIT_BUF: if (tx_buf_av >= BUF_MIN && !cfg_hold) state <= HDR0;
               HDR0:     if (s_axis_tx_tready) state <= HDR1;
               HDR1:     if (s_axis_tx_tready) state <= HDR2;
               HDR2:     if (s_axis_tx_tready) state <= DATA;
               DATA: begin
                  if (dat_valid && s_axis_tx_tready) begin
                     cnt_q <= cnt_q - 10'd1;
                     if (cnt_q == 10'd1)
                        state <= IDLE;
                  end
               end
               default:  state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pcie_tlp_tx_engine.sv
// tb/tb_pcie_tlp_tx_engine.sv - scoreboard bench for pcie_tlp_tx_engine.
`timescale 1ns/1ps
module tb_pcie_tlp_tx_engine;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        user_lnk_up = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_type = 1'b0;
   logic [9:0]  cmd_len = 10'd0;
   logic [31:0] cmd_addr = 32'h0;
   logic [7:0]  cmd_tag = 8'h0;
   logic [15:0] cmd_req_id = 16'h0;
   logic [15:0] cmd_cpl_id = 16'h0;
   logic [11:0] cmd_byte_count = 12'h0;
   logic [6:0]  cmd_lower_addr = 7'h0;
   logic [31:0] dat_data = 32'h0;
   logic        dat_valid = 1'b0;
   logic        dat_ready;
   logic        s_axis_tx_tready = 1'b1;
   logic [31:0] s_axis_tx_tdata;
   logic [3:0]  s_axis_tx_tkeep;
   logic [3:0]  s_axis_tx_tuser;
   logic        s_axis_tx_tlast;
   logic        s_axis_tx_tvalid;
   logic [5:0]  tx_buf_av = 6'd8;
   logic        tx_err_drop = 1'b0;
   logic        tx_cfg_req = 1'b0;
   logic        tx_cfg_gnt;
   logic        err_len;
   logic [7:0]  drop_count;
   logic        busy;

   pcie_tlp_tx_engine dut (
      .clk(clk), .rst(rst), .user_lnk_up(user_lnk_up),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_len(cmd_len), .cmd_addr(cmd_addr), .cmd_tag(cmd_tag),
      .cmd_req_id(cmd_req_id), .cmd_cpl_id(cmd_cpl_id),
      .cmd_byte_count(cmd_byte_count), .cmd_lower_addr(cmd_lower_addr),
      .dat_data(dat_data), .dat_valid(dat_valid), .dat_ready(dat_ready),
      .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tdata(s_axis_tx_tdata),
      .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tuser(s_axis_tx_tuser),
      .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
      .tx_buf_av(tx_buf_av), .tx_err_drop(tx_err_drop),
      .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
      .err_len(err_len), .drop_count(drop_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];
   logic [31:0] dat_q[$];
   logic [31:0] stage_q[$];
   bit          rand_stall = 1'b0;
   bit          hold_pend = 1'b0;
   logic [32:0] hold_beat;

   // Output monitor: every transferred beat is popped from the scoreboard; stalled beats must hold.
   always begin
      logic [32:0] got;
      logic [32:0] exp;
      @(negedge clk);
      got = {s_axis_tx_tlast, s_axis_tx_tdata};
      if (!rst && s_axis_tx_tvalid) begin
         if (hold_pend) begin
            checks++;
            if (got !== hold_beat) begin
               failures++;
               $display("FAIL stall_hold got=%h want=%h", got, hold_beat);
            end
         end
         if (s_axis_tx_tready) begin
            hold_pend = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL beat_unexpected got=%h want=none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  failures++;
                  $display("FAIL beat got=%h want=%h", got, exp);
               end
            end
         end else begin
            hold_pend = 1'b1;
            hold_beat = got;
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   // Payload source and tready driver.
   always begin
      bit dfire;
      @(negedge clk);
      dfire = dat_valid && dat_ready;
      @(posedge clk);
      #1;
      if (dfire && dat_q.size() > 0) void'(dat_q.pop_front());
      dat_valid = (dat_q.size() > 0);
      dat_data  = dat_valid ? dat_q[0] : 32'h0;
      s_axis_tx_tready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic t, input logic [9:0] len, input logic [31:0] addr,
                           input logic [7:0] tag, input logic [15:0] rid, input logic [15:0] cid,
                           input logic [11:0] bc, input logic [6:0] la, input int n_exp);
      logic [31:0] dw0, dw1, dw2;
      bit acc = 1'b0;
      dw0 = (t ? 32'h4A00_0000 : 32'h4000_0000) | {22'd0, len};
      dw1 = t ? {cid, 3'b000, 1'b0, bc} : {rid, tag, (len == 10'd1) ? 4'h0 : 4'hF, 4'hF};
      dw2 = t ? {rid, tag, 1'b0, la} : {addr[31:2], 2'b00};
      @(posedge clk);
      #1;
      if (n_exp >= 0) begin
         exp_q.push_back({1'b0, dw0});
         exp_q.push_back({1'b0, dw1});
         exp_q.push_back({1'b0, dw2});
         for (int i = 0; i < stage_q.size(); i++) begin
            dat_q.push_back(stage_q[i]);
            if (i < n_exp) exp_q.push_back({1'(i == int'(len) - 1), stage_q[i]});
         end
      end
      stage_q.delete();
      cmd_type = t; cmd_len = len; cmd_addr = addr; cmd_tag = tag;
      cmd_req_id = rid; cmd_cpl_id = cid; cmd_byte_count = bc; cmd_lower_addr = la;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (cmd_ready) acc = 1'b1;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL cmd_accept got=timeout want=cmd_ready");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string name);
      bit done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_complete got=busy%0d/left%0d want=idle", name, busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      user_lnk_up = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({s_axis_tx_tvalid, s_axis_tx_tlast, cmd_ready, dat_ready, err_len, busy} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=000000",
                  {s_axis_tx_tvalid, s_axis_tx_tlast, cmd_ready, dat_ready, err_len, busy});
      end
      checks++;
      if (s_axis_tx_tdata !== 32'h0 || drop_count !== 8'd0 || tx_cfg_gnt !== 1'b1) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%b want=0/0/1", s_axis_tx_tdata, drop_count, tx_cfg_gnt);
      end
      checks++;
      if (s_axis_tx_tkeep !== 4'hF || s_axis_tx_tuser !== 4'h0) begin
         failures++;
         $display("FAIL keep_user got=%h/%h want=f/0", s_axis_tx_tkeep, s_axis_tx_tuser);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready);
      end
   endtask

   task automatic test_mwr_len1();
      rand_stall = 1'b0;
      stage_q.push_back(32'hDEADBEEF);
      send_cmd(1'b0, 10'd1, 32'h1000_0004, 8'd5, 16'h0100, 16'h0, 12'h0, 7'h0, 1);
      @(negedge clk);
      checks++;
      if (s_axis_tx_tvalid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL latency_wait got=v%b/b%b want=v0/b1", s_axis_tx_tvalid, busy);
      end
      @(negedge clk);
      checks++;
      if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tdata !== 32'h4000_0001) begin
         failures++;
         $display("FAIL latency_hdr0 got=v%b/%h want=v1/40000001", s_axis_tx_tvalid, s_axis_tx_tdata);
      end
      wait_idle(50, "mwr_len1");
   endtask

   task automatic test_cpld_stall();
      rand_stall = 1'b1;
      for (int i = 0; i < 4; i++) stage_q.push_back($urandom);
      send_cmd(1'b1, 10'd4, 32'h0, 8'h22, 16'h0300, 16'h0200, 12'd16, 7'h10, 4);
      wait_idle(300, "cpld_stall");
      rand_stall = 1'b0;
   endtask

   task automatic test_bad_len(input logic [9:0] len);
      int pulses = 0;
      int vseen = 0;
      send_cmd(1'b0, len, 32'h2000_0000, 8'h1, 16'h0100, 16'h0, 12'h0, 7'h0, -1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (err_len === 1'b1) pulses++;
         if (s_axis_tx_tvalid === 1'b1 || busy === 1'b1) vseen++;
      end
      checks++;
      if (pulses != 1 || vseen != 0) begin
         failures++;
         $display("FAIL bad_len_%0d got=pulses%0d/active%0d want=pulses1/active0", len, pulses, vseen);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL bad_len_ready got=%b want=1", cmd_ready);
      end
   endtask

   task automatic test_buf_wait();
      int bad = 0;
      tx_buf_av = 6'd0;
      stage_q.push_back(32'h1111_2222);
      stage_q.push_back(32'h3333_4444);
      send_cmd(1'b0, 10'd2, 32'h0000_0100, 8'h7, 16'h0101, 16'h0, 12'h0, 7'h0, 2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (s_axis_tx_tvalid !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL buf_wait_hold got=%0d_bad_cycles want=0", bad);
      end
      @(posedge clk);
      #1;
      tx_buf_av = 6'd1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tdata !== 32'h4000_0002) begin
         failures++;
         $display("FAIL buf_release got=v%b/%h want=v1/40000002", s_axis_tx_tvalid, s_axis_tx_tdata);
      end
      wait_idle(50, "buf_wait");
      tx_buf_av = 6'd8;
   endtask

   task automatic test_link_loss();
      bit reached = 1'b0;
      for (int i = 0; i < 8; i++) stage_q.push_back(32'hA000_0000 + i);
      send_cmd(1'b0, 10'd8, 32'h3000_0000, 8'h9, 16'h0102, 16'h0, 12'h0, 7'h0, 1);
      for (int i = 0; i < 50 && !reached; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) reached = 1'b1;
      end
      user_lnk_up = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (!reached || s_axis_tx_tvalid !== 1'b0 || err_len !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL link_loss got=r%b/v%b/e%b/b%b want=r1/v0/e1/b0",
                  reached, s_axis_tx_tvalid, err_len, busy);
      end
      @(posedge clk);
      #1;
      dat_q.delete();
      user_lnk_up = 1'b1;
      wait_idle(10, "link_loss");
   endtask

   task automatic test_reset_mid();
      bit reached = 1'b0;
      int vseen = 0;
      for (int i = 0; i < 4; i++) stage_q.push_back(32'hB000_0000 + i);
      send_cmd(1'b0, 10'd4, 32'h4000_0000, 8'hA, 16'h0103, 16'h0, 12'h0, 7'h0, 1);
      for (int i = 0; i < 50 && !reached; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) reached = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      dat_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (s_axis_tx_tvalid !== 1'b0 || busy !== 1'b0) vseen++;
      end
      checks++;
      if (!reached || vseen != 0) begin
         failures++;
         $display("FAIL reset_mid got=r%b/active%0d want=r1/active0", reached, vseen);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) stage_q.push_back($urandom);
      send_cmd(1'b0, 10'd2, 32'h5000_0008, 8'h10, 16'h0104, 16'h0, 12'h0, 7'h0, 2);
      for (int i = 0; i < 3; i++) stage_q.push_back($urandom);
      send_cmd(1'b1, 10'd3, 32'h0, 8'h11, 16'h0105, 16'h0A0B, 12'd12, 7'h04, 3);
      wait_idle(100, "back_to_back");
   endtask

   task automatic test_drop_count();
      @(posedge clk);
      #1;
      tx_err_drop = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (drop_count !== 8'd10) begin
         failures++;
         $display("FAIL drop_count_10 got=%0d want=10", drop_count);
      end
      repeat (290) @(posedge clk);
      #1;
      tx_err_drop = 1'b0;
      checks++;
      if (drop_count !== 8'd255) begin
         failures++;
         $display("FAIL drop_count_sat got=%0d want=255", drop_count);
      end
   endtask

   task automatic test_cfg();
      int bad = 0;
      bit ended = 1'b0;
      bit reached = 1'b0;
      for (int i = 0; i < 4; i++) stage_q.push_back($urandom);
      send_cmd(1'b0, 10'd4, 32'h6000_0000, 8'h33, 16'h0106, 16'h0, 12'h0, 7'h0, 4);
`ifdef TX_CFG_DEFER_EN
      for (int i = 0; i < 50 && !reached; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() <= 4) reached = 1'b1;
      end
      tx_cfg_req = 1'b1;
      for (int i = 0; i < 50 && !ended; i++) begin
         @(negedge clk);
         if (!busy) ended = 1'b1;
         else if (tx_cfg_gnt !== 1'b0) bad++;
      end
      checks++;
      if (!reached || !ended || bad != 0 || tx_cfg_gnt !== 1'b1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL cfg_defer got=r%b/e%b/bad%0d/g%b want=r1/e1/bad0/g1",
                  reached, ended, bad, tx_cfg_gnt);
      end
      bad = 0;
      stage_q.push_back(32'hC0FF_EE00);
      send_cmd(1'b0, 10'd1, 32'h6000_0010, 8'h34, 16'h0106, 16'h0, 12'h0, 7'h0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || s_axis_tx_tvalid !== 1'b0 || tx_cfg_gnt !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL cfg_hold_wait got=%0d_bad_cycles want=0", bad);
      end
      @(posedge clk);
      #1;
      tx_cfg_req = 1'b0;
      wait_idle(50, "cfg_release");
`else
      tx_cfg_req = 1'b1;
      for (int i = 0; i < 50 && !ended; i++) begin
         @(negedge clk);
         if (tx_cfg_gnt !== 1'b1) bad++;
         if (!busy && exp_q.size() == 0) ended = 1'b1;
      end
      checks++;
      if (!ended || bad != 0 || reached) begin
         failures++;
         $display("FAIL cfg_ignore got=e%b/bad%0d want=e1/bad0", ended, bad);
      end
      tx_cfg_req = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_mwr_len1();
      test_cpld_stall();
      test_bad_len(10'd0);
      test_bad_len(10'd33);
      test_buf_wait();
      test_link_loss();
      test_reset_mid();
      test_back_to_back();
      test_cfg();
      test_drop_count();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcie_tlp_tx_engine.md
# pcie_tlp_tx_engine

Builds 32-bit PCIe transaction-layer packets (Memory Write 32 and Completion-with-Data) from a command/data request interface and drives them into the PCIe core's AXI-stream transmit port (`s_axis_tx_*`). It sits on the user-clock side of the PCIe AXI bridge, opposite the receive path, and is the single transmit master for the Wishbone/PCIe platform. It also arbitrates core-originated configuration transmissions (`tx_cfg_req`/`tx_cfg_gnt`) and counts TLPs dropped by the core.

## Interface
- `MAX_PAYLOAD_DW`, 32: largest legal `cmd_len` in DWs (1..1023).
- `BUF_AV_MIN`, 1: minimum `tx_buf_av` required before a TLP may start.

- `clk`  in  1  user clock from bridge `user_clk_out`
- `rst`  in  1  synchronous, active-high reset
- `user_lnk_up`  in  1  link up
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_type`  in  1  0 = MWr32, 1 = CplD
- `cmd_len`  in  10  payload length in DWs
- `cmd_addr`  in  32  MWr address; bits [1:0] ignored
- `cmd_tag`  in  8  tag
- `cmd_req_id`  in  16  requester ID
- `cmd_cpl_id`  in  16  completer ID (CplD only)
- `cmd_byte_count`  in  12  CplD byte count
- `cmd_lower_addr`  in  7  CplD lower address
- `dat_data`  in  32  payload DW
- `dat_valid` / `dat_ready`  in/out  1  payload handshake
- `s_axis_tx_tready`  in  1
- `s_axis_tx_tdata`  out  32
- `s_axis_tx_tkeep`  out  4  always 4'hF
- `s_axis_tx_tuser`  out  4  always 4'b0000
- `s_axis_tx_tlast`, `s_axis_tx_tvalid`  out  1
- `tx_buf_av`  in  6  core buffer availability
- `tx_err_drop`  in  1  core dropped a TLP
- `tx_cfg_req`  in  1  core wants to send a config TLP
- `tx_cfg_gnt`  out  1
- `err_len`  out  1  one-cycle pulse: illegal length or aborted TLP
- `drop_count`  out  8  saturating count of `tx_err_drop` cycles
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, WAIT_BUF, HDR0, HDR1, HDR2, DATA.
- IDLE: `cmd_ready = user_lnk_up`. On accept, all `cmd_*` fields latch. If `cmd_len == 0` or `cmd_len > MAX_PAYLOAD_DW`, pulse `err_len`, stay in IDLE, and emit nothing. Otherwise go to WAIT_BUF.
- WAIT_BUF: go to HDR0 when `tx_buf_av >= BUF_AV_MIN` (plus the config-hold rule below).
- Header beats (big-endian; byte 0 is in `tdata[31:24]`):
  - MWr DW0 = `32'h4000_0000 | len`.
  - MWr DW1 = `{req_id, tag, lastBE, 4'hF}`, where `lastBE` = 0 if len == 1, else 4'hF.
  - MWr DW2 = `{addr[31:2], 2'b00}`.
  - CplD DW0 = `32'h4A00_0000 | len`.
  - CplD DW1 = `{cpl_id, 3'b000, 1'b0, byte_count}`.
  - CplD DW2 = `{req_id, tag, 1'b0, lower_addr}`.
- HDRn: `tvalid = 1`. Advance on `tready`. HDR2 then goes to DATA.
- DATA:
  - `tvalid = dat_valid`, `dat_ready = tready`, `tdata = dat_data` (combinational pass-through).
  - A down-counter is loaded with `len` and decrements per transfer.
  - `tlast = 1` when the counter is 1.
  - The final transfer returns to IDLE. `dat_ready` is 0 in every other state.
- Link loss: if `user_lnk_up` = 0 in WAIT_BUF/HDRn/DATA, go to IDLE next cycle, drop `tvalid`, pulse `err_len`, and discard the command.
- `drop_count` increments on each cycle `tx_err_drop` = 1 and saturates at 255.

## Timing
- Reset values:
  - state = IDLE; `tvalid`, `tlast`, `cmd_ready`, `dat_ready`, `err_len`, `busy` = 0.
  - `tdata` = 0; `drop_count` = 0.
  - `tx_cfg_gnt` = 1.
- Latency: command accepted at edge N → WAIT_BUF at N+1 → earliest HDR0 `tvalid` in cycle N+2.
- Throughput: one DW per cycle under continuous `tready`/`dat_valid`. A TLP of L DWs takes L+3 beats.
- `tdata`/`tlast` hold stable while `tvalid & !tready`.
- Reset mid-packet returns to IDLE on the next edge with no further beats.

## Configuration
- `TX_CFG_DEFER_EN` defined:
  - `tx_cfg_gnt` = 1 only in IDLE, or in WAIT_BUF.
  - In WAIT_BUF, while `tx_cfg_req` = 1 the block does not leave WAIT_BUF, so config TLPs are never interleaved mid-packet.
- Undefined: `tx_cfg_gnt` is tied 1, and WAIT_BUF ignores `tx_cfg_req`.

## Test plan
- MWr, len 1, addr `32'h1000_0004`, tag 5, req_id `16'h0100`, data `32'hDEADBEEF`, `tready` always 1 → beats `40000001`, `01000500`... wait, with len 1 `lastBE` = 0 and firstBE = F, so DW1 = `0100050F`; then `10000004`, `DEADBEEF` with `tlast` on beat 4.
- CplD, len 4, cpl_id `16'h0200`, byte_count 16, lower_addr `7'h10`, tag `8'h22` → DW0 `4A000004`, DW1 `02000010`, DW2 `{req_id,22,10}`, four data DWs, `tlast` on beat 7. Random `tready` stalls must hold data stable.
- `cmd_len` = 0 and `cmd_len` = 33 (default parameter) → `err_len` pulses once each, no `tvalid`, `cmd_ready` returns to 1.
- `tx_buf_av` = 0 for 10 cycles after accept → stays in WAIT_BUF, `tvalid` = 0. Raising it to 1 gives HDR0 on the next cycle.
- Drop `user_lnk_up` during DATA beat 2 of 8 → `tvalid` = 0 next cycle, `err_len` pulses, `busy` = 0. Separately, `tx_err_drop` high for 300 cycles → `drop_count` = 255.
- With `TX_CFG_DEFER_EN`, `tx_cfg_req` = 1 during DATA → `tx_cfg_gnt` = 0 until the packet ends, then 1 in IDLE. A new command is held in WAIT_BUF while `tx_cfg_req` stays high.
